// File: rtl/rr_mux_4to1.sv
// rr_mux_4to1: fair round-robin combiner of four valid/ready source channels
// onto one registered output stream. Each output beat carries the 2-bit index
// of the channel it came from in out_sel, so a downstream demux can route by tag.
//
// Handshake: a beat moves across any interface on a rising clk edge where
// valid and ready are both high. in_ready is one-hot or zero and never depends
// on the same channel being accepted elsewhere. out_valid/out_data/out_sel stay
// stable while out_valid=1 and out_ready=0.
//
// Optional build macro RR_MUX_PKT_LOCK_EN: adds in_last/out_last and keeps the
// arbiter locked to one channel from its first beat until its last beat.
module rr_mux_4to1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [3:0]         in_last,
  output logic               out_last,
`endif
  output logic [3:0]         in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel
);

  // Rotation pointer: channel searched first on the next load.
  logic [1:0]       ptr;
  logic             load;
  logic [1:0]       grant;
  logic             grant_vld;
  logic [WIDTH-1:0] ch_data [4];

`ifdef RR_MUX_PKT_LOCK_EN
  // Packet lock: while set only lock_ch may be granted.
  logic             locked;
  logic [1:0]       lock_ch;
`endif

  // The output register may take a new beat when empty or being drained.
  assign load = !out_valid || out_ready;

  // Split the flat data bus into per-channel words.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority search: walk offsets downward so the smallest offset
  // from ptr that is valid is the one left standing.
  always_comb begin
    logic [1:0] cand;
    grant     = ptr;
    grant_vld = 1'b0;
    cand      = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (in_valid[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
`ifdef RR_MUX_PKT_LOCK_EN
    if (locked) begin
      grant     = lock_ch;
      grant_vld = in_valid[lock_ch];
    end
`endif
  end

  // Accept only the winner, and only when the output register can take it.
  always_comb begin
    in_ready = 4'b0000;
    if (load && grant_vld) begin
      in_ready = 4'b0001 << grant;
    end
  end

  // Output register, rotation pointer and packet lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'b00;
      ptr       <= 2'b00;
`ifdef RR_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= 2'b00;
`endif
    end else if (load) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant];
        out_sel   <= grant;
`ifdef RR_MUX_PKT_LOCK_EN
        out_last  <= in_last[grant];
        if (in_last[grant]) begin
          // Packet complete: release and move on past this channel.
          locked <= 1'b0;
          ptr    <= grant + 2'd1;
        end else begin
          // Mid-packet: stay on this channel, pointer frozen.
          locked  <= 1'b1;
          lock_ch <= grant;
        end
`else
        ptr       <= grant + 2'd1;
`endif
      end else begin
        // Nothing to send: drop valid, keep last data/tag for visibility.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
